min_width_reset_seq: RTL and testbench
======================================

# min_width_reset_seq

Multi-channel successor to the single-channel minimum-width resetter. Each channel stretches a sampled reset request to a guaranteed minimum width. A global request plus a per-channel stagger releases the domains in a fixed order: channel 0 first, highest channel last. It sits at the top of the clock domain and drives the block-level resets of downstream subsystems. The block also produces a power-on sequence from its own reset.

## Interface
- CHANNELS, 4: number of independent reset outputs; legal 1..32.
- MIN_WIDTH, 8: minimum assertion width of channel 0, in clk cycles; legal ≥1.
- STAGGER, 2: extra hold cycles per channel index; legal ≥0.
- SYNC_STAGES, 2: synchronizer flops on req_i/all_i; 0 = bypass (inputs already synchronous).
- Derived localparam: HOLD_c = MIN_WIDTH + c*STAGGER; CNT_W = $clog2(HOLD_(CHANNELS-1)+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_i  in  1  block reset, synchronous, active-high.
- req_i  in  CHANNELS  per-channel reset request, level, may be asynchronous.
- all_i  in  1  global request, equivalent to req_i all ones.
- rst_o  out  CHANNELS  stretched reset outputs, registered, active-high.
- busy_o  out  1  OR of rst_o.
- done_o  out  1  one-cycle pulse when the last active rst_o bit deasserts.

## Operation
- Synchronizer: SYNC_STAGES flops per req_i bit and for all_i, all cleared by rst_i.
  - Effective request r[c] = sync(req_i[c]) | sync(all_i).
- Per channel, at each edge, first match wins:
  - rst_i: rst_o[c]<=1, cnt[c]<=HOLD_c-1.
  - r[c]: rst_o[c]<=1, cnt[c]<=HOLD_c-1. This is a retrigger: the counter reloads on every sampled-high cycle.
  - cnt[c]!=0: rst_o[c]<=1, cnt[c]<=cnt[c]-1.
  - Otherwise: rst_o[c]<=0.
- Width rules:
  - A request sampled high for L≥1 consecutive cycles gives rst_o[c] high for exactly L+HOLD_c-1 cycles.
  - Minimum width is HOLD_c.
- Power-on: while rst_i is high, all rst_o are 1.
  - After rst_i falls, channels release staggered, in index order, STAGGER cycles apart.
  - STAGGER=0 releases all channels in the same cycle.
- Channels are fully independent. A request on one channel never alters another channel's counter.
- done_o is a registered pulse: high for exactly one cycle, aligned with the first cycle in which rst_o==0 after rst_o!=0.
  - done_o is never high while rst_i is high.
  - An overlapping retrigger postpones done_o; no pulse is emitted until the outputs actually reach all-zero.
- Arithmetic: counters are unsigned CNT_W bits and decrement-only. They never wrap, because decrement is gated by cnt!=0.

## Timing
- Reset values, during and on the first cycle after rst_i: rst_o = all ones, busy_o=1, done_o=0, sync flops 0, cnt[c]=HOLD_c-1.
- Latency: req_i rising before edge k gives rst_o[c] rising after edge k+SYNC_STAGES. That is 1 cycle with SYNC_STAGES=0, 3 cycles with the default.
- Release: rst_o[c] falls HOLD_c cycles after the last edge at which r[c] was sampled high.
- Pulses shorter than one clk period may be missed. A request must be held ≥1 full period to be guaranteed capture.
  - Once a pulse is captured, full width is guaranteed.
- Simultaneous req_i[c] and all_i behave as a single request.
- rst_i mid-stretch overrides all channels. Counters reload, and the release sequence restarts from the end of rst_i.
- A request arriving in the same cycle as cnt reaches 0 reloads. rst_o stays high with no gap and no done_o.
- HOLD_c=1 (MIN_WIDTH=1, c=0): width equals the sampled request length.

## Test plan
- Power-on sequencing:
  - Stimulus: defaults; rst_i high 3 cycles, then low.
  - Required: rst_o bits 0..3 stay high for 8/10/12/14 cycles after the last rst_i edge.
  - Required: done_o pulses once, aligned with rst_o==0.
- Single-cycle request:
  - Stimulus: SYNC_STAGES=0; req_i=4'b0010 for one cycle.
  - Required: rst_o[1] rises the next edge and stays high exactly 10 cycles. Other bits stay 0.
  - Required: busy_o mirrors rst_o[1]; done_o pulses once.
- Long request:
  - Stimulus: req_i[0] held 20 cycles.
  - Required: rst_o[0] high 27 cycles (20+8-1).
- Retrigger:
  - Stimulus: req_i[2] 1-cycle pulses 5 cycles apart, repeated 3 times.
  - Required: rst_o[2] is one continuous high of 10+12=22 cycles; exactly one done_o.
- Global request with default sync:
  - Stimulus: all_i pulse 1 cycle.
  - Required: all rst_o rise 3 edges later.
  - Required: release is staggered 2 cycles apart in index order; done_o appears after channel 3 falls.
- Reset mid-stretch, plus glitch:
  - Stimulus: req_i[3] pulse, then rst_i asserted 4 cycles into the stretch.
  - Required: all outputs go high; the full power-on sequence restarts from rst_i release.
  - Separately, a 2ns req glitch with a 10ns clk is either ignored or produces the full 8-cycle minimum width. A partial width is never allowed.

Source files
------------

// File: rtl/min_width_reset_seq_if.sv
// rtl/min_width_reset_seq_if.sv - request/reset bundle between requesters and the reset sequencer
interface min_width_reset_seq_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] req_i;
    logic                all_i;
    logic [CHANNELS-1:0] rst_o;
    logic                busy_o;
    logic                done_o;

    modport master (
        output req_i,
        output all_i,
        input  rst_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  req_i,
        input  all_i,
        output rst_o,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/min_width_reset_seq.sv
// rtl/min_width_reset_seq.sv - multi-channel minimum-width reset stretcher with staggered release
module min_width_reset_seq #(
    parameter int CHANNELS    = 4,
    parameter int MIN_WIDTH   = 8,
    parameter int STAGGER     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_i,
    min_width_reset_seq_if.slave  bus
);
    localparam int HOLD_MAX = MIN_WIDTH + (CHANNELS - 1) * STAGGER;
    localparam int CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
    // Keep at least one stage of storage so the bypass build still elaborates cleanly.
    localparam int SS       = (SYNC_STAGES > 0) ? SYNC_STAGES : 1;

    // Reload value for channel c: the channel stays high this many more edges after a trigger.
    function automatic logic [CNT_W-1:0] hold_m1(input int c);
        return CNT_W'(MIN_WIDTH + c * STAGGER - 1);
    endfunction

    logic [SS-1:0][CHANNELS-1:0]   sreq_q, sreq_d;
    logic [SS-1:0]                 sall_q, sall_d;
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0]           rst_o_q, rst_o_d;
    logic                          done_q, done_d;
    logic [CHANNELS-1:0]           req_eff;

    // Synchronizer shift chains: stage 0 captures the raw pins, the last stage feeds the channels.
    always_comb begin
        sreq_d    = sreq_q;
        sall_d    = sall_q;
        sreq_d[0] = bus.req_i;
        sall_d[0] = bus.all_i;
        for (int i = 1; i < SS; i++) begin
            sreq_d[i] = sreq_q[i-1];
            sall_d[i] = sall_q[i-1];
        end
    end

    // Effective request: a global request is just every channel asking at once.
    always_comb begin
        req_eff = '0;
        if (SYNC_STAGES == 0) begin
            req_eff = bus.req_i | {CHANNELS{bus.all_i}};
        end else begin
            req_eff = sreq_q[SS-1] | {CHANNELS{sall_q[SS-1]}};
        end
    end

    // Per-channel stretch: reset or request reloads, otherwise count down to release.
    always_comb begin
        cnt_d   = cnt_q;
        rst_o_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rst_i || req_eff[c]) begin
                rst_o_d[c] = 1'b1;
                cnt_d[c]   = hold_m1(c);
            end else if (cnt_q[c] != '0) begin
                rst_o_d[c] = 1'b1;
                cnt_d[c]   = cnt_q[c] - CNT_W'(1);
            end
        end
    end

    // done fires on the edge where the outputs go from some-active to all-clear.
    always_comb begin
        done_d = !rst_i && (|rst_o_q) && !(|rst_o_d);
    end

    // State registers; block reset leaves every channel asserted with a full hold loaded.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            sreq_q <= '0;
            sall_q <= '0;
            done_q <= 1'b0;
        end else begin
            sreq_q <= sreq_d;
            sall_q <= sall_d;
            done_q <= done_d;
        end
        cnt_q   <= cnt_d;
        rst_o_q <= rst_o_d;
    end

    assign bus.rst_o  = rst_o_q;
    assign bus.busy_o = |rst_o_q;
    assign bus.done_o = done_q;
endmodule

// File: tb/tb_min_width_reset_seq.sv
// tb/tb_min_width_reset_seq.sv - bench for min_width_reset_seq with default and bypassed synchronizers
module tb_min_width_reset_seq;
    localparam int CH = 4;
    localparam int NE = 2048;

    logic          clk = 1'b0;
    logic          drv_rst;
    logic [CH-1:0] drv_req;
    logic          drv_all;

    min_width_reset_seq_if #(.CHANNELS(CH)) if_s2 ();
    min_width_reset_seq_if #(.CHANNELS(CH)) if_s0 ();

    assign if_s2.req_i = drv_req;
    assign if_s2.all_i = drv_all;
    assign if_s0.req_i = drv_req;
    assign if_s0.all_i = drv_all;

    min_width_reset_seq #(.CHANNELS(CH), .MIN_WIDTH(8), .STAGGER(2), .SYNC_STAGES(2)) dut_s2 (
        .clk   (clk),
        .rst_i (drv_rst),
        .bus   (if_s2)
    );

    min_width_reset_seq #(.CHANNELS(CH), .MIN_WIDTH(8), .STAGGER(2), .SYNC_STAGES(0)) dut_s0 (
        .clk   (clk),
        .rst_i (drv_rst),
        .bus   (if_s0)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Model: a channel is held for HOLD_c edges after the latest edge that forced it
    // (block reset, or an input sample that has travelled through S sync edges undisturbed).
    int            ecount = 0;
    logic [CH-1:0] samp [NE];
    logic          rsth [NE];
    int            last_force [2][CH];
    logic [CH-1:0] exp_o [2];
    logic          exp_done [2];

    function automatic int hold(input int c);
        return 8 + 2 * c;
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) last_force[d][c] = -100000;
            exp_o[d]    = '0;
            exp_done[d] = 1'b0;
        end
    end

    always @(posedge clk) begin
        logic [CH-1:0] prev;
        ecount++;
        samp[ecount] = drv_req | {CH{drv_all}};
        rsth[ecount] = drv_rst;
        for (int d = 0; d < 2; d++) begin
            int s;
            s    = (d == 0) ? 2 : 0;
            prev = exp_o[d];
            for (int c = 0; c < CH; c++) begin
                logic f;
                f = rsth[ecount];
                if (!f) begin
                    if (s == 0) begin
                        f = samp[ecount][c];
                    end else if (ecount - s >= 1) begin
                        logic clean;
                        clean = 1'b1;
                        for (int j = ecount - s; j < ecount; j++) if (rsth[j]) clean = 1'b0;
                        f = clean && samp[ecount - s][c];
                    end
                end
                if (f) last_force[d][c] = ecount;
                exp_o[d][c] = (ecount - last_force[d][c]) < hold(c);
            end
            exp_done[d] = !rsth[ecount] && (prev != '0) && (exp_o[d] == '0);
        end
    end

    // Edge monitor: records the edge numbers of rises/falls and done pulses per DUT.
    int            rise_e [2][CH];
    int            fall_e [2][CH];
    int            done_n [2];
    int            done_e [2];
    logic [CH-1:0] prev_o [2];

    initial begin
        prev_o[0] = '1;
        prev_o[1] = '1;
    end

    task automatic clear_mon();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                rise_e[d][c] = -1;
                fall_e[d][c] = -1;
            end
            done_n[d] = 0;
            done_e[d] = -1;
        end
    endtask

    // Per-cycle compare against the model, sampled just after the active edge.
    always @(posedge clk) begin
        logic [CH-1:0] o [2];
        logic          dn [2];
        logic          bz [2];
        #1;
        o[0] = if_s2.rst_o;  dn[0] = if_s2.done_o;  bz[0] = if_s2.busy_o;
        o[1] = if_s0.rst_o;  dn[1] = if_s0.done_o;  bz[1] = if_s0.busy_o;
        for (int d = 0; d < 2; d++) begin
            chk(d == 0 ? "s2_rst_o" : "s0_rst_o", 32'(o[d]), 32'(exp_o[d]));
            chk(d == 0 ? "s2_busy_o" : "s0_busy_o", 32'(bz[d]), 32'(exp_o[d] != '0));
            chk(d == 0 ? "s2_done_o" : "s0_done_o", 32'(dn[d]), 32'(exp_done[d]));
            for (int c = 0; c < CH; c++) begin
                if (!prev_o[d][c] && o[d][c] === 1'b1) rise_e[d][c] = ecount;
                if (prev_o[d][c] && o[d][c] === 1'b0) fall_e[d][c] = ecount;
            end
            if (dn[d] === 1'b1) begin
                done_n[d]++;
                done_e[d] = ecount;
            end
            prev_o[d] = o[d];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int rst_last;
    int k;

    initial begin
        drv_rst = 1'b1;
        drv_req = '0;
        drv_all = 1'b0;
        clear_mon();

        // Power-on: three reset edges, then staggered release 8/10/12/14 edges later.
        tick(3);
        drv_rst  = 1'b0;
        rst_last = ecount;
        tick(20);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) chk("po_release", 32'(fall_e[d][c] - rst_last), 32'(hold(c)));
            chk("po_done_count", 32'(done_n[d]), 32'd1);
            chk("po_done_align", 32'(done_e[d]), 32'(fall_e[d][3]));
        end

        // Single-cycle request on channel 1.
        clear_mon();
        drv_req = 4'b0010;
        k       = ecount + 1;
        tick(1);
        drv_req = '0;
        tick(20);
        chk("single_rise_s0", 32'(rise_e[1][1]), 32'(k));
        chk("single_rise_s2", 32'(rise_e[0][1]), 32'(k + 2));
        for (int d = 0; d < 2; d++) begin
            chk("single_width", 32'(fall_e[d][1] - rise_e[d][1]), 32'd10);
            chk("single_other", 32'(rise_e[d][0] + rise_e[d][2] + rise_e[d][3]), 32'(-3));
            chk("single_done", 32'(done_n[d]), 32'd1);
        end

        // Long request on channel 0: 20 + 8 - 1.
        clear_mon();
        drv_req = 4'b0001;
        tick(20);
        drv_req = '0;
        tick(35);
        for (int d = 0; d < 2; d++) chk("long_width", 32'(fall_e[d][0] - rise_e[d][0]), 32'd27);

        // Retrigger on channel 2: pulses 5 apart merge into one 22-cycle stretch.
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            drv_req = 4'b0100;
            tick(1);
            drv_req = '0;
            tick(4);
        end
        tick(30);
        for (int d = 0; d < 2; d++) begin
            chk("retrig_width", 32'(fall_e[d][2] - rise_e[d][2]), 32'd22);
            chk("retrig_done", 32'(done_n[d]), 32'd1);
        end

        // Global request through the default synchronizer.
        clear_mon();
        drv_all = 1'b1;
        k       = ecount + 1;
        tick(1);
        drv_all = 1'b0;
        tick(25);
        for (int c = 0; c < CH; c++) begin
            chk("all_rise", 32'(rise_e[0][c]), 32'(k + 2));
            chk("all_fall", 32'(fall_e[0][c]), 32'(k + 2 + hold(c)));
        end
        chk("all_done_align", 32'(done_e[0]), 32'(fall_e[0][3]));
        chk("all_done_count", 32'(done_n[0]), 32'd1);

        // Reset mid-stretch restarts the full power-on release.
        clear_mon();
        drv_req = 4'b1000;
        tick(1);
        drv_req = '0;
        tick(4);
        drv_rst = 1'b1;
        tick(2);
        drv_rst  = 1'b0;
        rst_last = ecount;
        tick(25);
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) chk("midrst_release", 32'(fall_e[d][c] - rst_last), 32'(hold(c)));

        // Sub-period glitch between edges: ignored or full width, never partial.
        clear_mon();
        #2 drv_req = 4'b0001;
        #2 drv_req = '0;
        tick(15);
        for (int d = 0; d < 2; d++)
            chk("glitch_width_ok", 32'((rise_e[d][0] == -1) || (fall_e[d][0] - rise_e[d][0] == 8)), 32'd1);

        tick(2);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
